multicycle_stage_sequencer: RTL and testbench

- Parametrised successor to the fixed IF/ID/EX stage-enable generator in the processor control unit.
- Sequences each instruction through FETCH, DECODE, EXECUTE, optional MEMORY and optional WRITEBACK. Emits one-cycle stage enables consumed by the PC module, register file, ALU and data memory.
- Adds what the fixed generator lacks: req/ack handshakes for instruction and data memory with variable wait states, a wait timeout that raises a fault, single-step mode, halt at an instruction boundary, and a saturating retired-instruction counter.

---
 rtl/multicycle_stage_sequencer.sv | 163 ++++++++++++++++
 tb/tb_multicycle_stage_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_stage_sequencer
// Description : Multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK stage-enable
//               sequencer with memory handshakes, wait timeout and retire count.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_stage_sequencer #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic             halt_req,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             dec_is_load,
    input  logic             dec_is_store,
    input  logic             dec_writes_reg,
    output logic             en_fetch,
    output logic             en_decode,
    output logic             en_execute,
    output logic             en_memory,
    output logic             en_writeback,
    output logic             pc_update,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_FETCH     = 3'd1;
    localparam logic [2:0] c_DECODE    = 3'd2;
    localparam logic [2:0] c_EXECUTE   = 3'd3;
    localparam logic [2:0] c_MEMORY    = 3'd4;
    localparam logic [2:0] c_WRITEBACK = 3'd5;
    localparam logic [2:0] c_HALTED    = 3'd6;
    localparam logic [2:0] c_FAULT     = 3'd7;

    localparam logic [TO_W-1:0]  c_TIMEOUT  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]  c_WAIT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [2:0]       w_after_retire;
    logic [TO_W-1:0]  r_wait;
    logic             r_load;
    logic             r_store;
    logic             r_wr;
    logic [CNT_W-1:0] r_count;
    logic             r_fault;
    logic             w_waiting;
    logic             w_timeout;
    logic             w_retire;

    always_comb begin
        w_waiting = ((r_state == c_FETCH) && !imem_ack) ||
                    ((r_state == c_MEMORY) && !dmem_ack);
        // An ack arriving in the cycle the counter hits TIMEOUT still wins.
        w_timeout = w_waiting && (TIMEOUT != 0) && (r_wait >= c_TIMEOUT);
        w_retire  = ((r_state == c_EXECUTE) && !r_load && !r_store && !r_wr) ||
                    ((r_state == c_MEMORY) && dmem_ack && r_store) ||
                    (r_state == c_WRITEBACK);

        if (halt_req)
            w_after_retire = c_HALTED;
        else if (step_mode)
            w_after_retire = c_IDLE;
        else
            w_after_retire = c_FETCH;

        w_next = r_state;
        case (r_state)
            c_IDLE, c_HALTED: begin
                if (start)
                    w_next = c_FETCH;
            end
            c_FETCH: begin
                if (imem_ack)
                    w_next = c_DECODE;
                else if (w_timeout)
                    w_next = c_FAULT;
            end
            c_DECODE: begin
                w_next = c_EXECUTE;
            end
            c_EXECUTE: begin
                if (r_load || r_store)
                    w_next = c_MEMORY;
                else if (r_wr)
                    w_next = c_WRITEBACK;
                else
                    w_next = w_after_retire;
            end
            c_MEMORY: begin
                if (dmem_ack)
                    w_next = r_store ? w_after_retire : c_WRITEBACK;
                else if (w_timeout)
                    w_next = c_FAULT;
            end
            c_WRITEBACK: begin
                w_next = w_after_retire;
            end
            default: begin
                w_next = c_FAULT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
            r_wait  <= '0;
            r_load  <= 1'b0;
            r_store <= 1'b0;
            r_wr    <= 1'b0;
            r_count <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;

            // Any non-waiting cycle clears the counter, so entry to FETCH/MEMORY starts at 0.
            if (!w_waiting)
                r_wait <= '0;
            else if (r_wait != c_WAIT_MAX)
                r_wait <= r_wait + 1'b1;

            if (r_state == c_DECODE) begin
                r_load  <= dec_is_load & ~dec_is_store;
                r_store <= dec_is_store;
                r_wr    <= dec_writes_reg;
            end

            if (w_retire && (r_count != c_CNT_MAX))
                r_count <= r_count + 1'b1;

            if (w_timeout)
                r_fault <= 1'b1;
        end
    end

    assign imem_req      = (r_state == c_FETCH);
    assign en_fetch      = (r_state == c_FETCH) && imem_ack;
    assign en_decode     = (r_state == c_DECODE);
    assign en_execute    = (r_state == c_EXECUTE);
    assign dmem_req      = (r_state == c_MEMORY);
    assign dmem_we       = (r_state == c_MEMORY) && r_store;
    assign en_memory     = (r_state == c_MEMORY) && dmem_ack;
    assign en_writeback  = (r_state == c_WRITEBACK);
    assign pc_update     = w_retire;
    assign busy          = (r_state != c_IDLE) && (r_state != c_HALTED) && (r_state != c_FAULT);
    assign fault         = r_fault;
    assign retired_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_stage_sequencer
// Description : Randomized scoreboard bench for multicycle_stage_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_stage_sequencer;

    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 4;
    localparam int TO_W    = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             step_mode = 1'b0;
    logic             halt_req = 1'b0;
    logic             imem_req;
    logic             imem_ack = 1'b0;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack = 1'b0;
    logic             dec_is_load = 1'b0;
    logic             dec_is_store = 1'b0;
    logic             dec_writes_reg = 1'b0;
    logic             en_fetch;
    logic             en_decode;
    logic             en_execute;
    logic             en_memory;
    logic             en_writeback;
    logic             pc_update;
    logic             busy;
    logic             fault;
    logic [CNT_W-1:0] retired_count;

    always #5 clock = ~clock;

    multicycle_stage_sequencer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .step_mode      (step_mode),
        .halt_req       (halt_req),
        .imem_req       (imem_req),
        .imem_ack       (imem_ack),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_ack       (dmem_ack),
        .dec_is_load    (dec_is_load),
        .dec_is_store   (dec_is_store),
        .dec_writes_reg (dec_writes_reg),
        .en_fetch       (en_fetch),
        .en_decode      (en_decode),
        .en_execute     (en_execute),
        .en_memory      (en_memory),
        .en_writeback   (en_writeback),
        .pc_update      (pc_update),
        .busy           (busy),
        .fault          (fault),
        .retired_count  (retired_count)
    );

    // Expected per-instruction outcome: fetch-to-retire distance, which stage
    // retires ({execute,memory,writeback}), store flag, count after, busy after.
    typedef struct {
        int       lat;
        bit [2:0] kind;
        bit       we;
        int       cnt;
        bit       nbusy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_retired = 0;
    bit   need_start = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- monitor ----------------
    int   cyc = 0;
    int   f_cyc = 0;
    bit   pend = 1'b0;
    exp_t cur;

    always @(negedge clock) begin
        cyc++;
        if (pend) begin
            check("retired_count_after_retire", retired_count, cur.cnt);
            check("busy_after_retire", busy, cur.nbusy);
            pend = 1'b0;
        end
        check("enables_onehot",
              $countones({en_fetch, en_decode, en_execute, en_memory, en_writeback}) <= 1, 1);
        if (en_fetch)
            f_cyc = cyc;
        if (dmem_req && sb.size() > 0)
            check("dmem_we", dmem_we, sb[0].we);
        if (pc_update) begin
            if (sb.size() == 0) begin
                check("unexpected_pc_update", pc_update, 0);
            end else begin
                cur = sb.pop_front();
                check("retire_latency", cyc - f_cyc, cur.lat);
                check("retire_stage", {en_execute, en_memory, en_writeback}, cur.kind);
                pend = 1'b1;
            end
        end
    end

    // ---------------- driver / reference model ----------------
    task automatic do_reset();
        reset_n = 1'b0;
        start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        halt_req = 1'b0; step_mode = 1'b0;
        tick();
        tick();
        check("reset_outputs",
              {imem_req, dmem_req, dmem_we, en_fetch, en_decode, en_execute,
               en_memory, en_writeback, pc_update, busy, fault}, 0);
        check("reset_count", retired_count, 0);
        reset_n = 1'b1;
        n_retired = 0;
        need_start = 1'b1;
        sb.delete();
    endtask

    task automatic begin_fetch();
        if (need_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        check("imem_req_in_fetch", imem_req, 1);
    endtask

    task automatic run_instr(input bit ld, input bit st, input bit wr, input int iw,
                             input int dw, input bit stp, input bit hlt);
        exp_t e;
        bit   mem;
        bit   wb;
        step_mode = stp;
        halt_req  = hlt;
        begin_fetch();
        mem = ld | st;
        wb  = st ? 1'b0 : (ld ? 1'b1 : wr);
        n_retired++;
        e.lat   = 2 + (mem ? 1 + dw : 0) + (wb ? 1 : 0);
        e.kind  = wb ? 3'b001 : (mem ? 3'b010 : 3'b100);
        e.we    = st;
        e.cnt   = (n_retired > CNT_MAX) ? CNT_MAX : n_retired;
        e.nbusy = !(hlt || stp);
        sb.push_back(e);
        repeat (iw) tick();
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        dec_is_load = ld; dec_is_store = st; dec_writes_reg = wr;
        start = 1'($urandom_range(0, 1));
        tick();
        // Decoded flags must be held internally; scramble the live inputs.
        dec_is_load = 1'($urandom_range(0, 1));
        dec_is_store = 1'($urandom_range(0, 1));
        dec_writes_reg = 1'($urandom_range(0, 1));
        start = 1'b0;
        tick();
        if (mem) begin
            repeat (dw) tick();
            dmem_ack = 1'b1;
            tick();
            dmem_ack = 1'b0;
        end
        if (mem && wb)
            tick();
        else if (!mem && wb)
            tick();
        halt_req  = 1'b0;
        step_mode = 1'b0;
        need_start = hlt || stp;
    endtask

    task automatic random_batch(input int n);
        for (int i = 0; i < n; i++) begin
            run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 1)),
                      $urandom_range(0, TIMEOUT), $urandom_range(0, TIMEOUT),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0);
        end
    endtask

    initial begin
        do_reset();

        // ALU with write, fetch ack on the second FETCH cycle.
        run_instr(1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0);
        // Load and store with three data wait cycles.
        run_instr(1'b1, 1'b0, 1'b0, 0, 3, 1'b0, 1'b0);
        run_instr(1'b0, 1'b1, 1'b0, 0, 3, 1'b0, 1'b0);
        // Load+store together behaves as a store.
        run_instr(1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
        // Step mode: three stepped ALU instructions.
        for (int i = 0; i < 3; i++)
            run_instr(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        // Ack exactly on the timeout boundary.
        run_instr(1'b1, 1'b0, 1'b1, TIMEOUT, TIMEOUT, 1'b0, 1'b1);
        tick();
        check("halted_not_busy", busy, 0);

        random_batch(40);

        // Reset while a store is waiting in MEMORY.
        begin_fetch();
        imem_ack = 1'b1; tick(); imem_ack = 1'b0;
        dec_is_store = 1'b1; dec_is_load = 1'b0; dec_writes_reg = 1'b0;
        tick(); tick();
        check("mid_mem_dmem_req", dmem_req, 1);
        check("mid_mem_dmem_we", dmem_we, 1);
        check("mid_mem_count_nonzero", retired_count, CNT_MAX);
        reset_n = 1'b0;
        tick();
        check("reset_mid_mem_dmem_req", dmem_req, 0);
        check("reset_mid_mem_busy", busy, 0);
        check("reset_mid_mem_count", retired_count, 0);
        do_reset();

        // Fetch timeout.
        begin_fetch();
        for (int i = 0; i <= TIMEOUT; i++) begin
            check("fetch_wait_req", imem_req, 1);
            check("fetch_wait_nofault", fault, 0);
            tick();
        end
        check("fetch_timeout_fault", fault, 1);
        check("fetch_timeout_req", imem_req, 0);
        start = 1'b1; tick(); tick(); start = 1'b0;
        check("fault_ignores_start_fault", fault, 1);
        check("fault_ignores_start_busy", {busy, imem_req}, 0);
        do_reset();
        check("fault_cleared", fault, 0);

        // Data memory timeout.
        begin_fetch();
        imem_ack = 1'b1; tick(); imem_ack = 1'b0;
        dec_is_load = 1'b1; dec_is_store = 1'b0; dec_writes_reg = 1'b1;
        tick(); tick();
        for (int i = 0; i <= TIMEOUT; i++) begin
            check("mem_wait_req", {dmem_req, dmem_we, fault}, 3'b100);
            tick();
        end
        check("mem_timeout_fault", {fault, dmem_req, en_writeback, pc_update}, 4'b1000);
        do_reset();

        random_batch(15);
        repeat (3) tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
